// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port word memory between the fetch port (A)
// and the load/store port (B); every access runs IDLE -> ACCESS -> RESP.
module mem_arbiter #(
  parameter logic [15:0] ADDR_MAX = 16'd100,
  parameter int          RR_MODE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [15:0] a_addr,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        err,
  output logic        busy,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] address,
  output logic [15:0] dataIN,
  input  logic [15:0] dataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        last_b;
  logic        lat_b;
  logic        lat_we;
  logic        lat_oor;
  logic        pick_b;
  logic [15:0] sel_addr;
  logic        sel_store;
  logic        sel_ok;

  // Winner selection for the IDLE sampling edge; a lone requester always wins.
  always_comb begin
    pick_b = b_req;
    if (a_req && b_req)
      pick_b = (RR_MODE != 0) ? !last_b : 1'b1;
    sel_addr  = pick_b ? b_addr : a_addr;
    sel_store = pick_b && b_we;
    sel_ok    = (sel_addr <= ADDR_MAX);
  end

  // The address register doubles as the latched request address, so the
  // strobes can be launched directly from the IDLE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_b   <= 1'b0;
      lat_b    <= 1'b0;
      lat_we   <= 1'b0;
      lat_oor  <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      address  <= '0;
      dataIN   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            lat_b    <= pick_b;
            last_b   <= pick_b;
            lat_we   <= sel_store;
            lat_oor  <= !sel_ok;
            address  <= sel_addr;
            memRead  <= sel_ok && !sel_store;
            memWrite <= sel_ok && sel_store;
            if (sel_ok && sel_store)
              dataIN <= b_wdata;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          memRead  <= 1'b0;
          memWrite <= 1'b0;
          // Rejected accesses return zero; in-range stores leave rdata untouched.
          if (lat_b) begin
            if (lat_oor)
              b_rdata <= '0;
            else if (!lat_we)
              b_rdata <= dataOut;
          end else begin
            if (lat_oor)
              a_rdata <= '0;
            else
              a_rdata <= dataOut;
          end
          a_ack <= !lat_b;
          b_ack <= lat_b;
          err   <= lat_oor;
          state <= RESP;
        end
        RESP: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model feeds a scoreboard
// queue that a monitor drains on every ack; a second instance covers fixed priority.
module tb_mem_arbiter;

  localparam logic [15:0] ADDR_MAX = 16'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, b_addr = '0, b_wdata = '0, dataOut = '0;
  logic        a_ack, b_ack, err, busy, memRead, memWrite;
  logic [15:0] a_rdata, b_rdata, address, dataIN;

  logic        f_a_req = 1'b0, f_b_req = 1'b0, f_b_we = 1'b0;
  logic [15:0] f_a_addr = '0, f_b_addr = '0, f_b_wdata = '0;
  logic [15:0] f_dataOut = 16'h1234;
  logic        f_a_ack, f_b_ack, f_err, f_busy, f_memRead, f_memWrite;
  logic [15:0] f_a_rdata, f_b_rdata, f_address, f_dataIN;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_MAX(ADDR_MAX), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .err(err), .busy(busy),
    .memRead(memRead), .memWrite(memWrite), .address(address),
    .dataIN(dataIN), .dataOut(dataOut)
  );

  mem_arbiter #(.ADDR_MAX(ADDR_MAX), .RR_MODE(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .a_req(f_a_req), .a_addr(f_a_addr), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
    .b_req(f_b_req), .b_we(f_b_we), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
    .b_ack(f_b_ack), .b_rdata(f_b_rdata), .err(f_err), .busy(f_busy),
    .memRead(f_memRead), .memWrite(f_memWrite), .address(f_address),
    .dataIN(f_dataIN), .dataOut(f_dataOut)
  );

  // Memory behaviour: writes land on the rising edge, reads update on the falling edge.
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  always @(posedge clk)
    if (memWrite && address < 16'd256) mem[address[7:0]] <= dataIN;

  always @(negedge clk)
    if (memRead) dataOut <= mem[address[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          port_b;
    int          ack_cyc;
    logic [15:0] addr;
    bit          we;
    logic [15:0] wdata;
    bit          oor;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   cyc = 0;
  int   next_free = 0;
  bit   model_last_b = 1'b0;
  txn_t new_t;
  txn_t mon_e;

  // Reference model: one access may start every third edge; the winner follows
  // the round-robin rule and the response is known as soon as it is granted.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      next_free    = 0;
      model_last_b = 1'b0;
    end else if (cyc >= next_free && (a_req || b_req)) begin
      new_t.port_b  = (a_req && b_req) ? !model_last_b : b_req;
      model_last_b  = new_t.port_b;
      new_t.addr    = new_t.port_b ? b_addr : a_addr;
      new_t.we      = new_t.port_b && b_we;
      new_t.wdata   = b_wdata;
      new_t.oor     = new_t.addr > ADDR_MAX;
      new_t.rdata   = new_t.oor ? 16'h0000 : ref_mem[new_t.addr[7:0]];
      if (new_t.we && !new_t.oor) ref_mem[new_t.addr[7:0]] = new_t.wdata;
      new_t.ack_cyc = cyc + 1;
      next_free     = cyc + 3;
      exp_q.push_back(new_t);
    end
  end

  // Monitor: compares the bus and the responses against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      chk("strobe_overlap", {31'd0, memRead & memWrite}, 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0 && exp_q[0].ack_cyc == cyc + 1) begin
        chk("mem_read", {31'd0, memRead}, {31'd0, !exp_q[0].oor && !exp_q[0].we});
        chk("mem_write", {31'd0, memWrite}, {31'd0, !exp_q[0].oor && exp_q[0].we});
        if (!exp_q[0].oor) chk("mem_address", {16'd0, address}, {16'd0, exp_q[0].addr});
        if (!exp_q[0].oor && exp_q[0].we) chk("mem_wdata", {16'd0, dataIN}, {16'd0, exp_q[0].wdata});
      end else begin
        chk("idle_strobes", {30'd0, memRead, memWrite}, 32'd0);
      end
      if (a_ack || b_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, a_ack, b_ack}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_port", {30'd0, a_ack, b_ack}, mon_e.port_b ? 32'd1 : 32'd2);
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          chk("err", {31'd0, err}, {31'd0, mon_e.oor});
          if (!mon_e.we || mon_e.oor)
            chk("rdata", {16'd0, mon_e.port_b ? b_rdata : a_rdata}, {16'd0, mon_e.rdata});
        end
      end else begin
        chk("err_without_ack", {31'd0, err}, 32'd0);
        if (exp_q.size() != 0 && exp_q[0].ack_cyc < cyc) begin
          chk("ack_missing", {30'd0, a_ack, b_ack}, exp_q[0].port_b ? 32'd1 : 32'd2);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drivers assume they start just after a rising edge and leave it that way.
  task automatic do_a(input logic [15:0] addr, input bit hold);
    bit got = 1'b0;
    a_req  = 1'b1;
    a_addr = addr;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = a_ack;
    end
    if (!got) chk("a_ack_wait", {31'd0, a_ack}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) a_req = 1'b0;
  endtask

  task automatic do_b(input bit we, input logic [15:0] addr, input logic [15:0] wdata, input bit hold);
    bit got = 1'b0;
    b_req   = 1'b1;
    b_we    = we;
    b_addr  = addr;
    b_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = b_ack;
    end
    if (!got) chk("b_ack_wait", {31'd0, b_ack}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) b_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] pre;
    int nb;
    int na;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[10]     = 16'h00A5;
    ref_mem[10] = 16'h00A5;

    #12;
    chk("reset_ctrl", {26'd0, a_ack, b_ack, err, busy, memRead, memWrite}, 32'd0);
    chk("reset_rdata", {a_rdata, b_rdata}, 32'd0);
    chk("reset_bus", {address, dataIN}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Fetch, store/load of a negative value, out-of-range store.
    do_a(16'd10, 1'b0);
    chk("fetch_a5", {16'd0, a_rdata}, 32'h00A5);
    do_b(1'b1, 16'd12, 16'hFFFE, 1'b0);
    do_b(1'b0, 16'd12, 16'h0000, 1'b0);
    chk("load_neg2", {16'd0, b_rdata}, 32'h0000FFFE);
    pre = mem[101];
    do_b(1'b1, 16'd101, 16'h5555, 1'b0);
    chk("oor_mem_untouched", {16'd0, mem[101]}, {16'd0, pre});
    chk("oor_rdata_zero", {16'd0, b_rdata}, 32'd0);

    // Both ports requesting continuously: grants must alternate.
    fork
      begin
        for (int i = 0; i < 2; i++) do_b(1'b0, 16'(20 + i), 16'h0, i == 0);
      end
      begin
        for (int i = 0; i < 2; i++) do_a(16'(30 + i), i == 0);
      end
    join

    // Reset in the middle of a read access.
    a_req  = 1'b1;
    a_addr = 16'd40;
    @(posedge clk);
    #2;
    chk("rst_pre_read", {31'd0, memRead}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_drop", {30'd0, memRead, busy}, 32'd0);
    a_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_ack", {30'd0, a_ack, busy}, 32'd0);
    @(posedge clk);
    #1;
    do_a(16'd40, 1'b0);
    chk("post_reset_fetch", {16'd0, a_rdata}, {16'd0, ref_mem[40]});

    // Randomised traffic on both ports.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          bit h;
          h = (i != 29) && ($urandom_range(0, 1) == 1);
          do_a(16'($urandom_range(0, 110)), h);
          if (!h) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          bit h;
          h = (i != 29) && ($urandom_range(0, 1) == 1);
          do_b(1'($urandom_range(0, 1)), 16'($urandom_range(0, 110)), 16'($urandom), h);
          if (!h) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    // Fixed priority: B starves A until B lets go.
    f_a_req  = 1'b1;
    f_a_addr = 16'd3;
    f_b_req  = 1'b1;
    f_b_addr = 16'd5;
    nb = 0;
    na = 0;
    for (int i = 0; i < 40 && nb < 4; i++) begin
      @(negedge clk);
      if (f_b_ack) nb++;
      if (f_a_ack) na++;
    end
    chk("fixed_b_acks", nb, 32'd4);
    chk("fixed_a_starved", na, 32'd0);
    chk("fixed_b_rdata", {16'd0, f_b_rdata}, 32'h1234);
    @(posedge clk);
    #1 f_b_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("fixed_a_ack", {30'd0, f_a_ack, f_b_ack}, 32'd2);
    chk("fixed_a_rdata", {16'd0, f_a_rdata}, 32'h1234);
    @(posedge clk);
    #1 f_a_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared single-port 16-bit word memory of the multi-cycle CPU.
- Port A is the instruction-fetch path (read-only). Port B is the load/store data path.
- The block serialises both ports onto the memory's memRead/memWrite/address/dataIN/dataOut interface with a req/ack handshake.
- It range-checks addresses and returns signed read data to the winning requester.

Parameters:
ADDR_MAX, 100, highest legal word address; accesses above it are rejected.
RR_MODE, 1, 1 = round-robin between A and B; 0 = fixed priority with B over A.

Ports:
clk  input  1  system clock, rising-edge logic.
rst  input  1  asynchronous, active-low reset.
a_req  input  1  fetch request; held high until a_ack.
a_addr  input  16  fetch word address.
a_ack  output  1  one-cycle completion pulse for A.
a_rdata  output  16  signed fetch data; valid while a_ack is high and held until the next A completion.
b_req  input  1  data request; held high until b_ack.
b_we  input  1  1 = store, 0 = load.
b_addr  input  16  data word address.
b_wdata  input  16  signed store data.
b_ack  output  1  one-cycle completion pulse for B.
b_rdata  output  16  signed load data; same validity rule as a_rdata.
err  output  1  pulses with the ack when the address exceeds ADDR_MAX.
busy  output  1  high in ACCESS and RESP states.
memRead  output  1  memory read strobe.
memWrite  output  1  memory write strobe.
address  output  16  memory address.
dataIN  output  16  memory write data.
dataOut  input  16  memory read data; memory updates it on the falling clock edge while memRead is high.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE and all outputs go to 0.
  - last_grant is set to A, so the first simultaneous request goes to B.
  - Any in-flight access is aborted immediately: strobes drop, and no ack is issued after reset releases.
- State IDLE:
  - At a rising edge with any req high, latch winner, address, we and wdata, then go to ACCESS.
  - Arbitration when only one req is high: that requester wins.
  - Arbitration when both are high: with RR_MODE=1 the port opposite to last_grant wins; with RR_MODE=0, B wins.
  - last_grant updates to the winner at latch time.
- State ACCESS (exactly one cycle):
  - address is driven from the latched value.
  - Load or fetch: memRead=1. Store: memWrite=1 and dataIN = latched wdata.
  - The memory captures a write at the closing rising edge. For a read, dataOut is valid at the falling edge inside this cycle.
  - At the closing rising edge, dataOut is registered into the winner's rdata, then the state goes to RESP.
- Out-of-range address (latched address > ADDR_MAX, unsigned compare):
  - No strobe is asserted in ACCESS and the winner's rdata is set to 0.
  - err is asserted together with the ack in RESP.
- State RESP (one cycle):
  - The winner's ack is 1 (err also, if flagged); memory strobes are 0.
  - A req still high during RESP is ignored; the next state is always IDLE.
- Latency:
  - req sampled at edge N: ACCESS runs in cycle N+1, ack is high in cycle N+2, next IDLE is cycle N+3.
  - Minimum issue interval is 3 cycles per access.
- Memory strobe rules:
  - memRead and memWrite are never high simultaneously, and never high outside ACCESS.
  - address and dataIN hold their last values outside ACCESS; strobes return to 0.
- Fairness:
  - With RR_MODE=1, a continuously requesting port waits at most one foreign access (worst-case ack at 6 cycles).
  - With RR_MODE=0, A may starve; this is accepted.
- Request rules:
  - a_req is treated as read-only; there is no A write path.
  - Request inputs are sampled only in IDLE; changing addr/wdata after the latch has no effect.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then a_req=1, a_addr=10, with MEM[10]=0x00A5 → memRead high for 1 cycle with address=10; a_ack high 2 cycles after the sampling edge; a_rdata=0x00A5; err=0.
2. b_req=1, b_we=1, b_addr=12, b_wdata=0xFFFE, then b_we=0 load of address 12 → memWrite pulses 1 cycle with dataIN=0xFFFE; the load returns b_rdata=0xFFFE (signed −2); both acks are single-cycle.
3. RR_MODE=1, both reqs held high continuously from reset → grant order B, A, B, A; acks 3 cycles apart; memRead/memWrite never overlap.
4. RR_MODE=0, both reqs high for 4 accesses → only b_ack pulses; a_ack stays 0 until b_req drops, then a_ack follows 2 cycles after the next IDLE sample.
5. b_req store to b_addr=101 → no memWrite pulse; b_ack=1 with err=1; b_rdata=0; MEM contents unchanged.
6. rst driven low in the middle of an ACCESS cycle of a read → memRead drops without waiting for a clock edge; no ack after release; busy=0; the next request completes normally.
